// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the writeback-arbiter slot count.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   localparam int WB_NSLOT = 2;
endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding register; a load in the same cycle as a clear wins.
module wb_slot
   import cpu_types_pkg::*;
(
   input  logic     CLK,
   input  logic     nRST,
   input  logic     i_load,
   input  logic     i_clear,
   input  regbits_t i_sel,
   input  word_t    i_dat,
   output logic     o_full,
   output regbits_t o_sel,
   output word_t    o_dat
);
   logic     r_full;
   regbits_t r_sel;
   word_t    r_dat;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_full <= 1'b0;
         r_sel  <= '0;
         r_dat  <= '0;
      end else if (i_load) begin
         r_full <= 1'b1;
         r_sel  <= i_sel;
         r_dat  <= i_dat;
      end else if (i_clear) begin
         r_full <= 1'b0;
      end
   end

   assign o_full = r_full;
   assign o_sel  = r_sel;
   assign o_dat  = r_dat;
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback through
// two one-entry slots drained oldest-first, with a pending-write query port.
module regfile_write_arbiter
   import cpu_types_pkg::*;
#(
   parameter int NSLOT = WB_NSLOT
)
(
   input  logic             CLK,
   input  logic             nRST,
   input  logic [NSLOT-1:0] req,
   output logic [NSLOT-1:0] rdy,
   input  regbits_t         wsel0,
   input  regbits_t         wsel1,
   input  word_t            wdat0,
   input  word_t            wdat1,
   output logic             rf_wen,
   output regbits_t         rf_wsel,
   output word_t            rf_wdat,
   input  regbits_t         qsel,
   output logic             qhit,
   output word_t            qdat
);
   regbits_t         w_in_sel [NSLOT];
   word_t            w_in_dat [NSLOT];
   regbits_t         w_sel    [NSLOT];
   word_t            w_dat    [NSLOT];
   logic [NSLOT-1:0] w_full, w_grant, w_load, w_keep, w_hit;
   logic             r_age;

   assign w_in_sel[0] = wsel0;
   assign w_in_sel[1] = wsel1;
   assign w_in_dat[0] = wdat0;
   assign w_in_dat[1] = wdat1;

   genvar gi;
   generate
      for (gi = 0; gi < NSLOT; gi++) begin : g_slot
         assign rdy[gi]    = !w_full[gi] || w_grant[gi];
         // Writes to r0 complete the handshake but never occupy the slot.
         assign w_load[gi] = req[gi] && rdy[gi] && (w_in_sel[gi] != '0);
         assign w_keep[gi] = w_full[gi] && !w_grant[gi];
         assign w_hit[gi]  = w_full[gi] && (w_sel[gi] == qsel) && (qsel != '0);

         wb_slot u_slot (
            .CLK     (CLK),
            .nRST    (nRST),
            .i_load  (w_load[gi]),
            .i_clear (w_grant[gi]),
            .i_sel   (w_in_sel[gi]),
            .i_dat   (w_in_dat[gi]),
            .o_full  (w_full[gi]),
            .o_sel   (w_sel[gi]),
            .o_dat   (w_dat[gi])
         );
      end
   endgenerate

   // Grant is suppressed while in reset so buffered values never reach the file.
   always_comb begin
      w_grant = '0;
      if (w_full[0] && w_full[1]) begin
         w_grant = r_age ? 2'b10 : 2'b01;
      end else begin
         w_grant = w_full;
      end
      if (!nRST) begin
         w_grant = '0;
      end
   end

   // r_age = 1 means slot 1 holds the older entry.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_age <= 1'b0;
      end else if (w_load[0] && w_load[1]) begin
         r_age <= 1'b0;
      end else if (w_load[0]) begin
         r_age <= w_keep[1];
      end else if (w_load[1]) begin
         r_age <= !w_keep[0];
      end
   end

   always_comb begin
      rf_wen  = |w_grant;
      rf_wsel = '0;
      rf_wdat = '0;
      if (w_grant[1]) begin
         rf_wsel = w_sel[1];
         rf_wdat = w_dat[1];
      end else if (w_grant[0]) begin
         rf_wsel = w_sel[0];
         rf_wdat = w_dat[0];
      end
   end

   always_comb begin
      qhit = |w_hit;
      qdat = '0;
      if (w_hit[0] && w_hit[1]) begin
         qdat = r_age ? w_dat[0] : w_dat[1];
      end else if (w_hit[0]) begin
         qdat = w_dat[0];
      end else if (w_hit[1]) begin
         qdat = w_dat[1];
      end
   end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writeback requesters: requester 0 is the ALU/execute writeback and requester 1 is the load/memory writeback. Each requester has a one-entry holding slot. An oldest-first arbiter drains one slot per cycle into the write port. A query port reports pending (buffered, not yet written) values to the hazard/forwarding logic.

## Interface
Parameters:
- NSLOT, 2, number of requesters. Fixed at 2; no other value is supported.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- nRST  in  1  reset; one clock, synchronous, active-low.
- req  in  [1:0]  requester i presents a write this cycle.
- rdy  out  [1:0]  slot i can accept this cycle.
- wsel0, wsel1  in  regbits_t (5)  destination register of each requester.
- wdat0, wdat1  in  word_t (32)  write data of each requester.
- rf_wen  out  1  register file write enable.
- rf_wsel  out  regbits_t  register file write select.
- rf_wdat  out  word_t  register file write data.
- qsel  in  regbits_t  register being queried by hazard logic.
- qhit  out  1  a buffered write to qsel is pending.
- qdat  out  word_t  youngest pending value for qsel.

## Operation
- Handshake: the write is accepted on a posedge where `req[i] && rdy[i]`.
  - `rdy[i] = !full[i] || grant[i]`, so a refill in the same cycle as the drain is allowed.
  - The requester holds `req`/`wsel`/`wdat` until accepted.
- Writes to register 0 are accepted and discarded. The slot stays empty and does not change `age`.
- Each slot holds: `full`, `sel`, `dat`.
- `age` bit: 1 means slot 1 is older.
  - When one slot fills while the other is already full, the filling slot becomes the younger one.
  - When both slots fill in the same cycle, slot 0 is the older one.
- Grant rule (combinational from slot state): grant the oldest full slot. If only one slot is full, grant it. If neither is full, grant nothing.
  - Draining in age order preserves program order when both slots target the same register.
- Write port outputs:
  - `rf_wen = |grant`.
  - `rf_wsel`/`rf_wdat` come from the granted slot; they are 0 when there is no grant.
  - The granted slot empties at the posedge.
- Query port:
  - `qhit` = any full slot with `sel == qsel`, and `qsel != 0`.
  - `qdat` = data of the youngest matching slot, else 0.
  - Slots are sampled before this cycle's drain, so the slot being written this cycle still counts as a hit.
- Throughput: one write per cycle. With both requesters streaming, writes alternate (age order).

## Timing
- Reset (nRST low at posedge): both slots empty, `age = 0`. The next cycle shows `rdy = 2'b11`, `rf_wen = 0`, `qhit = 0`, and all data outputs 0.
  - Reset during any operation discards buffered writes.
  - `req` during the reset cycle is ignored.
- Latency:
  - Accept at edge N puts the write in its slot during cycle N+1.
  - If that slot is the oldest, `rf_wen` is high in N+1, and the register file holds the value after edge N+1.
  - A slot that has to wait behind the other slot is written in N+2.
- Simultaneous events:
  - A drain and a refill of the same slot in one cycle: the new entry is the younger one if the other slot is full.
  - Both slots full, one drained, both requesting: only the drained slot has `rdy` high.
- Outputs other than the registered slot state are combinational. There is no combinational path from `req` to `rdy`.

## Structure
- `word_t` and `regbits_t` come from `cpu_types_pkg`. Add `WB_NSLOT = 2` to the same package.
- Sub-module `wb_slot`: a one-entry holding register with load/clear, exposing `full`/`sel`/`dat`. It is instantiated twice.
- The top level contains the age bit, grant logic, write-port mux and query mux.
- `rf_*` connect to `register_file_if.rf` wen/wsel/wdat.

## Test plan
- Reset, then a single write on requester 0 (`wsel0=5`, `wdat0=32'hDEAD_BEEF`) -> `rdy = 11`, `rf_wen` high for exactly one cycle with `wsel = 5`, and `qhit` high for `qsel = 5` during that cycle only.
- Both requesters in the same cycle (`wsel0=3`/`32'h1`, `wsel1=4`/`32'h2`) -> reg 3 written in cycle N+1, reg 4 in N+2.
- Same register: requester 1 writes reg 7 = `32'hA`, and one cycle later, while that slot is still blocked, requester 0 writes reg 7 = `32'hB` -> the final value of reg 7 is `32'hB`, and `qdat` reads `32'hB` while both slots are full.
- Write to reg 0 (`wdat = 32'hFFFF_FFFF`) -> accepted, `rf_wen` never high, `qhit` 0 for `qsel = 0`.
- Both requesters stream 8 writes each -> 16 writes with no loss and no duplicates, one per cycle, and each requester's writes stay in its own order.
- nRST low with both slots full -> on the next cycle `rdy = 11`, `rf_wen = 0`, `qhit = 0`, and neither buffered value is ever written.
